// File: rtl/dtw_accel_m00_axis_pkg.sv
// rtl/dtw_accel_m00_axis_pkg.sv - shared types and helpers for the DTW result stream path
//
// Purpose: clogb2 helper, default data width, tx state encoding and the
// {last, data} FIFO entry layout used by the result FIFO and the stream master.
// Ports: none (package).
package dtw_accel_pkg;

  localparam int C_DATA_WIDTH = 32;

  // Smallest n with 2**n >= depth.
  function automatic int clogb2(input int depth);
    int r;
    int v;
    r = 0;
    v = depth - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  typedef struct packed {
    logic                    last;
    logic [C_DATA_WIDTH-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/dtw_accel_m00_axis_if.sv
// rtl/dtw_accel_m00_axis_if.sv - AXI4-Stream bus bundle for the DTW result path
//
// Purpose: groups the M_AXIS beat signals.
// Ports (modport master): out TVALID, TDATA, TSTRB, TLAST; in TREADY.
// Ports (modport slave):  the mirror image.
interface dtw_accel_m00_axis_if
  import dtw_accel_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = C_DATA_WIDTH
);
  logic                              M_AXIS_TVALID;
  logic [C_M_AXIS_TDATA_WIDTH-1:0]   M_AXIS_TDATA;
  logic [C_M_AXIS_TDATA_WIDTH/8-1:0] M_AXIS_TSTRB;
  logic                              M_AXIS_TLAST;
  logic                              M_AXIS_TREADY;

  modport master (
    output M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST,
    input  M_AXIS_TREADY
  );

  modport slave (
    input  M_AXIS_TVALID, M_AXIS_TDATA, M_AXIS_TSTRB, M_AXIS_TLAST,
    output M_AXIS_TREADY
  );
endinterface

// File: rtl/dtw_accel_m00_axis_tx_fifo.sv
// rtl/dtw_accel_m00_axis_tx_fifo.sv - synchronous result FIFO feeding the stream master
//
// Purpose: power-of-two depth FIFO with show-ahead (combinational) read data.
// Ports: clk, rst (async, active-high); wren/din write side; rden pop;
//        dout = head entry; full, empty, count = entries held.
module dtw_accel_tx_fifo
  import dtw_accel_pkg::*;
#(
  parameter int WIDTH = C_DATA_WIDTH + 1,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wren,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rden,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [clogb2(DEPTH):0]   count
);
  localparam int AW = clogb2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count_r;
  logic             do_wr;
  logic             do_rd;

  assign full  = (count_r == (AW+1)'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;
  assign dout  = mem[rd_ptr];

  // A write while full is refused even if a pop happens on the same edge.
  assign do_wr = wren && !full;
  assign do_rd = rden && !empty;

  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_r <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count_r <= count_r + 1'b1;
        2'b01:   count_r <= count_r - 1'b1;
        default: count_r <= count_r;
      endcase
    end
  end
endmodule

// File: rtl/dtw_accel_m00_axis.sv
// rtl/dtw_accel_m00_axis.sv - AXI4-Stream master draining DTW results as packets
//
// Purpose: buffers DTW core result words and emits them on M_AXIS in packets
// of up to PKT_LEN beats; a word flagged last closes the packet early.
// Ports: M_AXIS_ACLK, M_AXIS_ARESET (async, active-high);
//        dtw_fifo_wren/din/last write port; dtw_fifo_full/count/overflow status;
//        pkt_count = TLAST handshakes (wraps); m_axis = stream master bundle.
module dtw_accel_m00_axis
  import dtw_accel_pkg::*;
#(
  parameter int C_M_AXIS_TDATA_WIDTH = C_DATA_WIDTH,
  parameter int FIFO_DEPTH           = 8,
  parameter int PKT_LEN              = 4
) (
  input  logic                            M_AXIS_ACLK,
  input  logic                            M_AXIS_ARESET,
  input  logic                            dtw_fifo_wren,
  input  logic [C_M_AXIS_TDATA_WIDTH-1:0] dtw_fifo_din,
  input  logic                            dtw_fifo_last,
  output logic                            dtw_fifo_full,
  output logic [clogb2(FIFO_DEPTH):0]     dtw_fifo_count,
  output logic                            dtw_fifo_overflow,
  output logic [15:0]                     pkt_count,
  dtw_accel_m00_axis_if.master            m_axis
);
  localparam int W  = C_M_AXIS_TDATA_WIDTH;
  localparam int BW = (clogb2(PKT_LEN) > 0) ? clogb2(PKT_LEN) : 1;

  tx_state_t      state;
  logic           tvalid_r;
  logic           tlast_r;
  logic [W-1:0]   tdata_r;
  logic [BW-1:0]  beat_idx;
  logic [W:0]     fifo_dout;
  logic           fifo_empty;
  logic           load;
  logic           next_last;
  logic           handshake;

  dtw_accel_tx_fifo #(
    .WIDTH (W + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (M_AXIS_ACLK),
    .rst   (M_AXIS_ARESET),
    .wren  (dtw_fifo_wren),
    .din   ({dtw_fifo_last, dtw_fifo_din}),
    .rden  (load),
    .dout  (fifo_dout),
    .full  (dtw_fifo_full),
    .empty (fifo_empty),
    .count (dtw_fifo_count)
  );

  // The output register refills whenever it is empty or being drained this
  // cycle, so a steady stream moves one beat per clock.
  assign handshake = tvalid_r && m_axis.M_AXIS_TREADY;
  assign load      = (!tvalid_r || m_axis.M_AXIS_TREADY) && !fifo_empty;
  assign next_last = fifo_dout[W] || (beat_idx == BW'(PKT_LEN - 1));

  assign m_axis.M_AXIS_TVALID = tvalid_r;
  assign m_axis.M_AXIS_TDATA  = tdata_r;
  assign m_axis.M_AXIS_TLAST  = tlast_r;
  assign m_axis.M_AXIS_TSTRB  = '1;

  always_ff @(posedge M_AXIS_ACLK or posedge M_AXIS_ARESET) begin
    if (M_AXIS_ARESET) begin
      state             <= IDLE;
      tvalid_r          <= 1'b0;
      tlast_r           <= 1'b0;
      tdata_r           <= '0;
      beat_idx          <= '0;
      pkt_count         <= '0;
      dtw_fifo_overflow <= 1'b0;
    end else begin
      if (dtw_fifo_wren && dtw_fifo_full) dtw_fifo_overflow <= 1'b1;
      if (handshake && tlast_r) pkt_count <= pkt_count + 16'd1;

      // TDATA/TLAST only change on load, which never fires while stalled.
      if (load) begin
        tdata_r  <= fifo_dout[W-1:0];
        tlast_r  <= next_last;
        beat_idx <= next_last ? '0 : beat_idx + 1'b1;
      end

      case (state)
        IDLE: begin
          if (load) begin
            state    <= SEND;
            tvalid_r <= 1'b1;
          end
        end
        SEND: begin
          // Beat taken and nothing left to reload.
          if (m_axis.M_AXIS_TREADY && !load) begin
            state    <= IDLE;
            tvalid_r <= 1'b0;
          end
        end
        default: begin
          state    <= IDLE;
          tvalid_r <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_dtw_accel_m00_axis.sv
// tb/tb_dtw_accel_m00_axis.sv - directed self-checking bench for dtw_accel_m00_axis
module tb_dtw_accel_m00_axis;
  import dtw_accel_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wren = 1'b0;
  logic [31:0] din = '0;
  logic        last = 1'b0;
  logic        full;
  logic [3:0]  count;
  logic        overflow;
  logic [15:0] pkt_count;

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;

  fifo_entry_t mon_q[$];
  int          mon_cyc[$];

  dtw_accel_m00_axis_if #(.C_M_AXIS_TDATA_WIDTH(32)) axis ();

  dtw_accel_m00_axis #(
    .C_M_AXIS_TDATA_WIDTH (32),
    .FIFO_DEPTH           (8),
    .PKT_LEN              (4)
  ) dut (
    .M_AXIS_ACLK       (clk),
    .M_AXIS_ARESET     (rst),
    .dtw_fifo_wren     (wren),
    .dtw_fifo_din      (din),
    .dtw_fifo_last     (last),
    .dtw_fifo_full     (full),
    .dtw_fifo_count    (count),
    .dtw_fifo_overflow (overflow),
    .pkt_count         (pkt_count),
    .m_axis            (axis.master)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Handshakes are recorded half a cycle before the edge that completes them.
  always @(negedge clk) begin
    if (!rst && axis.M_AXIS_TVALID && axis.M_AXIS_TREADY) begin
      mon_q.push_back({axis.M_AXIS_TLAST, axis.M_AXIS_TDATA});
      mon_cyc.push_back(cyc);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    wren = 1'b0;
    last = 1'b0;
    din = '0;
    axis.M_AXIS_TREADY = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    mon_q.delete();
    mon_cyc.delete();
  endtask

  task automatic write_word(input logic [31:0] d, input logic l);
    wren = 1'b1;
    din = d;
    last = l;
    tick();
    wren = 1'b0;
    last = 1'b0;
  endtask

  task automatic wait_beats(input int n);
    int k;
    k = 0;
    while (mon_q.size() < n && k < 60) begin
      tick();
      k++;
    end
    tick();
    tick();
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    axis.M_AXIS_TREADY = 1'b0;
    tick();
    tests_run++;
    if (axis.M_AXIS_TVALID !== 1'b0 || axis.M_AXIS_TLAST !== 1'b0 || axis.M_AXIS_TDATA !== 32'h0) begin
      tests_failed++;
      $display("FAIL reset_beat: got v=%b l=%b d=%0h expected 0 0 0", axis.M_AXIS_TVALID, axis.M_AXIS_TLAST, axis.M_AXIS_TDATA);
    end
    tests_run++;
    if (axis.M_AXIS_TSTRB !== 4'hF) begin
      tests_failed++;
      $display("FAIL reset_tstrb: got %0h expected f", axis.M_AXIS_TSTRB);
    end
    tests_run++;
    if (full !== 1'b0 || count !== 4'd0 || overflow !== 1'b0 || pkt_count !== 16'd0) begin
      tests_failed++;
      $display("FAIL reset_status: got full=%b cnt=%0d ovf=%b pkt=%0d expected 0 0 0 0", full, count, overflow, pkt_count);
    end
    rst = 1'b0;
  endtask

  task automatic test_stream();
    do_reset();
    axis.M_AXIS_TREADY = 1'b1;
    wren = 1'b1;
    din = 32'h1;
    tick();
    tests_run++;
    if (axis.M_AXIS_TVALID !== 1'b0) begin
      tests_failed++;
      $display("FAIL stream_latency_e1: got tvalid=%b expected 0", axis.M_AXIS_TVALID);
    end
    din = 32'h2;
    tick();
    tests_run++;
    if (axis.M_AXIS_TVALID !== 1'b1 || axis.M_AXIS_TDATA !== 32'h1) begin
      tests_failed++;
      $display("FAIL stream_latency_e2: got v=%b d=%0h expected 1 1", axis.M_AXIS_TVALID, axis.M_AXIS_TDATA);
    end
    for (int d = 3; d <= 8; d++) begin
      din = d;
      tick();
    end
    wren = 1'b0;
    wait_beats(8);
    tests_run++;
    if (mon_q.size() !== 8) begin
      tests_failed++;
      $display("FAIL stream_beats: got %0d expected 8", mon_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        tests_run++;
        if (mon_q[i].data !== 32'(i + 1) || mon_q[i].last !== (i == 3 || i == 7) || mon_cyc[i] !== mon_cyc[0] + i) begin
          tests_failed++;
          $display("FAIL stream_beat%0d: got d=%0h l=%b dc=%0d expected d=%0h l=%b dc=%0d", i, mon_q[i].data, mon_q[i].last, mon_cyc[i] - mon_cyc[0], i + 1, (i == 3 || i == 7), i);
        end
      end
    end
    tests_run++;
    if (pkt_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL stream_pkt_count: got %0d expected 2", pkt_count);
    end
  endtask

  task automatic test_early_last();
    logic [31:0] ed [6];
    logic        el [6];
    ed = '{32'hA, 32'hB, 32'hC, 32'hD, 32'hE, 32'hF};
    el = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    axis.M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < 6; i++) write_word(ed[i], (i == 1));
    wait_beats(6);
    tests_run++;
    if (mon_q.size() !== 6) begin
      tests_failed++;
      $display("FAIL early_last_beats: got %0d expected 6", mon_q.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        tests_run++;
        if (mon_q[i].data !== ed[i] || mon_q[i].last !== el[i]) begin
          tests_failed++;
          $display("FAIL early_last_beat%0d: got d=%0h l=%b expected d=%0h l=%b", i, mon_q[i].data, mon_q[i].last, ed[i], el[i]);
        end
      end
    end
    tests_run++;
    if (pkt_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL early_last_pkt_count: got %0d expected 2", pkt_count);
    end
  endtask

  task automatic test_backpressure();
    do_reset();
    for (int i = 0; i < 4; i++) write_word(32'h21 + i, 1'b0);
    tick();
    for (int k = 0; k < 5; k++) begin
      tests_run++;
      if (axis.M_AXIS_TVALID !== 1'b1 || axis.M_AXIS_TDATA !== 32'h21 || axis.M_AXIS_TLAST !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold%0d: got v=%b d=%0h l=%b expected 1 21 0", k, axis.M_AXIS_TVALID, axis.M_AXIS_TDATA, axis.M_AXIS_TLAST);
      end
      tick();
    end
    for (int k = 0; k < 20 && mon_q.size() < 4; k++) begin
      axis.M_AXIS_TREADY = ~axis.M_AXIS_TREADY;
      tick();
    end
    axis.M_AXIS_TREADY = 1'b0;
    tick();
    tests_run++;
    if (mon_q.size() !== 4) begin
      tests_failed++;
      $display("FAIL bp_beats: got %0d expected 4", mon_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (mon_q[i].data !== 32'h21 + i || mon_q[i].last !== (i == 3)) begin
          tests_failed++;
          $display("FAIL bp_beat%0d: got d=%0h l=%b expected d=%0h l=%b", i, mon_q[i].data, mon_q[i].last, 32'h21 + i, (i == 3));
        end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 1; i <= 10; i++) begin
      wren = 1'b1;
      din = 32'h30 + i;
      tick();
      if (i == 8) begin
        tests_run++;
        if (full !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_not_full_8: got full=%b expected 0", full);
        end
      end
      if (i == 9) begin
        tests_run++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
          tests_failed++;
          $display("FAIL ovf_full_9: got full=%b ovf=%b expected 1 0", full, overflow);
        end
      end
    end
    wren = 1'b0;
    tests_run++;
    if (overflow !== 1'b1 || count !== 4'd8 || full !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovf_after_10: got ovf=%b cnt=%0d full=%b expected 1 8 1", overflow, count, full);
    end
    axis.M_AXIS_TREADY = 1'b1;
    wait_beats(9);
    tests_run++;
    if (mon_q.size() !== 9) begin
      tests_failed++;
      $display("FAIL ovf_beats: got %0d expected 9", mon_q.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        tests_run++;
        if (mon_q[i].data !== 32'h31 + i || mon_q[i].last !== (i == 3 || i == 7)) begin
          tests_failed++;
          $display("FAIL ovf_beat%0d: got d=%0h l=%b expected d=%0h l=%b", i, mon_q[i].data, mon_q[i].last, 32'h31 + i, (i == 3 || i == 7));
        end
      end
    end
    tests_run++;
    if (overflow !== 1'b1 || count !== 4'd0 || pkt_count !== 16'd2) begin
      tests_failed++;
      $display("FAIL ovf_drained: got ovf=%b cnt=%0d pkt=%0d expected 1 0 2", overflow, count, pkt_count);
    end
  endtask

  task automatic test_simul_wr_pop();
    do_reset();
    for (int i = 0; i < 4; i++) write_word(32'h41 + i, 1'b0);
    tick();
    tests_run++;
    if (count !== 4'd3 || axis.M_AXIS_TDATA !== 32'h41) begin
      tests_failed++;
      $display("FAIL simul_pre: got cnt=%0d d=%0h expected 3 41", count, axis.M_AXIS_TDATA);
    end
    axis.M_AXIS_TREADY = 1'b1;
    wren = 1'b1;
    din = 32'h45;
    tick();
    wren = 1'b0;
    tests_run++;
    if (count !== 4'd3 || axis.M_AXIS_TDATA !== 32'h42) begin
      tests_failed++;
      $display("FAIL simul_count: got cnt=%0d d=%0h expected 3 42", count, axis.M_AXIS_TDATA);
    end
    wait_beats(5);
    tests_run++;
    if (mon_q.size() !== 5) begin
      tests_failed++;
      $display("FAIL simul_beats: got %0d expected 5", mon_q.size());
    end else begin
      for (int i = 0; i < 5; i++) begin
        tests_run++;
        if (mon_q[i].data !== 32'h41 + i || mon_q[i].last !== (i == 3)) begin
          tests_failed++;
          $display("FAIL simul_beat%0d: got d=%0h l=%b expected d=%0h l=%b", i, mon_q[i].data, mon_q[i].last, 32'h41 + i, (i == 3));
        end
      end
    end
  endtask

  task automatic test_reset_mid_packet();
    do_reset();
    axis.M_AXIS_TREADY = 1'b1;
    write_word(32'h50, 1'b1);
    wait_beats(1);
    tests_run++;
    if (pkt_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL mid_pre_pkt: got %0d expected 1", pkt_count);
    end
    axis.M_AXIS_TREADY = 1'b0;
    for (int i = 0; i < 4; i++) write_word(32'h51 + i, 1'b0);
    tick();
    axis.M_AXIS_TREADY = 1'b1;
    tick();
    tick();
    axis.M_AXIS_TREADY = 1'b0;
    tests_run++;
    if (mon_q.size() !== 3 || axis.M_AXIS_TDATA !== 32'h53 || axis.M_AXIS_TVALID !== 1'b1) begin
      tests_failed++;
      $display("FAIL mid_two_beats: got n=%0d d=%0h v=%b expected 3 53 1", mon_q.size(), axis.M_AXIS_TDATA, axis.M_AXIS_TVALID);
    end
    #3;
    rst = 1'b1;
    #1;
    tests_run++;
    if (axis.M_AXIS_TVALID !== 1'b0 || count !== 4'd0 || pkt_count !== 16'd0 || axis.M_AXIS_TLAST !== 1'b0) begin
      tests_failed++;
      $display("FAIL mid_async_reset: got v=%b cnt=%0d pkt=%0d l=%b expected 0 0 0 0", axis.M_AXIS_TVALID, count, pkt_count, axis.M_AXIS_TLAST);
    end
    tick();
    rst = 1'b0;
    mon_q.delete();
    mon_cyc.delete();
    axis.M_AXIS_TREADY = 1'b1;
    for (int i = 0; i < 4; i++) write_word(32'h61 + i, 1'b0);
    wait_beats(4);
    tests_run++;
    if (mon_q.size() !== 4) begin
      tests_failed++;
      $display("FAIL mid_fresh_beats: got %0d expected 4", mon_q.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        tests_run++;
        if (mon_q[i].data !== 32'h61 + i || mon_q[i].last !== (i == 3)) begin
          tests_failed++;
          $display("FAIL mid_fresh_beat%0d: got d=%0h l=%b expected d=%0h l=%b", i, mon_q[i].data, mon_q[i].last, 32'h61 + i, (i == 3));
        end
      end
    end
    tests_run++;
    if (pkt_count !== 16'd1) begin
      tests_failed++;
      $display("FAIL mid_fresh_pkt: got %0d expected 1", pkt_count);
    end
  endtask

  initial begin
    axis.M_AXIS_TREADY = 1'b0;
    test_reset();
    test_stream();
    test_early_last();
    test_backpressure();
    test_overflow();
    test_simul_wr_pop();
    test_reset_mid_packet();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/dtw_accel_m00_axis.md
Name: dtw_accel_m00_axis

Overview:
AXI4-Stream master source for the DTW accelerator result path, the transmit counterpart of the sample-input sink.
- The DTW core pushes result words into an internal FIFO through a simple write port.
- The block drains the FIFO onto M_AXIS as packets of PKT_LEN beats, or shorter when the core marks a word as last.
- It sits between the DTW core output and the DMA S2MM channel.

Parameters:
C_M_AXIS_TDATA_WIDTH, 32, AXI stream data width and DTW result word width
FIFO_DEPTH, 8, result FIFO entries; power of two, at least 2
PKT_LEN, 4, maximum beats per packet; TLAST is forced on beat PKT_LEN-1

Ports:
M_AXIS_ACLK  in  1  single clock for all logic
M_AXIS_ARESET  in  1  reset, asynchronous, active-high
dtw_fifo_wren  in  1  DTW core write strobe
dtw_fifo_din  in  C_M_AXIS_TDATA_WIDTH  result word
dtw_fifo_last  in  1  marks din as final word of a result set (qualified by wren)
dtw_fifo_full  out  1  FIFO holds FIFO_DEPTH words
dtw_fifo_count  out  clogb2(FIFO_DEPTH)+1  words held in FIFO, excluding the output register
dtw_fifo_overflow  out  1  sticky: a write was attempted while full
pkt_count  out  16  completed packets (TLAST handshakes); wraps at 2^16
M_AXIS_TVALID  out  1  beat valid
M_AXIS_TDATA  out  C_M_AXIS_TDATA_WIDTH  beat data
M_AXIS_TSTRB  out  C_M_AXIS_TDATA_WIDTH/8  constant all ones
M_AXIS_TLAST  out  1  packet boundary
M_AXIS_TREADY  in  1  downstream ready

Behaviour:
- Reset (M_AXIS_ARESET=1, asynchronous) clears all state. Every output reads 0, except TSTRB, which stays all ones. Pointers, beat index and state (IDLE) also clear.
- Reset mid-packet drops any held beat, clears TVALID immediately, discards FIFO contents and clears pkt_count and overflow. No TLAST is emitted for the truncated packet.
- FIFO entries are width+1 bits: {last, data}.
  - A write is accepted when wren && !full. Writing while full drops the word and sets dtw_fifo_overflow.
  - Write and read pointers wrap from FIFO_DEPTH-1 to 0.
  - A simultaneous write and pop keeps the count unchanged. A write while full is dropped even if a pop occurs on the same edge.
- Output register holds one beat: TDATA, TLAST, TVALID.
  - load = (!TVALID || TREADY) && fifo not empty.
  - On load, the FIFO head pops into the register, giving full throughput at one beat per cycle.
- State machine:
  - IDLE (TVALID=0): go to SEND on load.
  - SEND (TVALID=1):
    - stay in SEND while TREADY=0; TDATA and TLAST are held stable (AXI rule);
    - on handshake with FIFO non-empty, reload and stay in SEND;
    - on handshake with FIFO empty, go to IDLE and drop TVALID.
- Latency: a word accepted at edge k makes TVALID visible after edge k+1.
- TLAST is computed at load: TLAST = entry.last || (beat_idx == PKT_LEN-1).
  - beat_idx, width clogb2(PKT_LEN), increments on each load.
  - beat_idx returns to 0 on a load whose TLAST is 1.
- pkt_count increments on every handshake with TLAST=1.
- TVALID never depends combinationally on TREADY.

Decomposition:
- Package dtw_accel_pkg holds:
  - clogb2 function;
  - data width constant;
  - tx state encoding {IDLE, SEND};
  - FIFO entry type {last, data}.
- One sub-module, dtw_accel_tx_fifo: synchronous FIFO with parameters width and depth. It exposes wren, din, rden, dout, full, empty, count, and the top level owns the overflow flag.

Test Plan:
1. Continuous stream: reset, write 8 words 0x1..0x8, last=0, TREADY=1 → 8 back-to-back beats. TLAST on 0x4 and 0x8; pkt_count=2; TVALID first high one cycle after the first write edge.
2. Early last: write 0xA, 0xB (last=1), then 0xC..0xF → packets {A,B} and {C,D,E,F}, each ending with TLAST; pkt_count=2.
3. Backpressure: TREADY low for 5 cycles with TVALID high → TDATA and TLAST stable. Toggle TREADY 1/0 alternately → every word appears exactly once, in order.
4. Full/overflow: TREADY=0, write 10 words → full after the 9th write attempt (8 in FIFO + 1 held in the output register), 10th dropped, overflow=1, count=8. Release TREADY → exactly 9 words emerge.
5. Simultaneous write and pop at count=3 → count stays 3 and ordering is preserved.
6. Reset mid-packet after 2 beats of 4 → TVALID=0 immediately, count=0, pkt_count=0. New writes start a fresh packet with TLAST on its 4th beat.
